// File: rtl/led_status_pkg.sv
// Shared types and constants for the LED status scheduler: FSM states, pattern codes
// and the pattern decode helper.
package led_status_pkg;

    localparam int unsigned PH_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        REARB = 2'd2
    } state_t;

    localparam logic [1:0] PAT_OFF  = 2'd0;
    localparam logic [1:0] PAT_ON   = 2'd1;
    localparam logic [1:0] PAT_SLOW = 2'd2;
    localparam logic [1:0] PAT_FAST = 2'd3;

    function automatic logic pat_decode(input logic [1:0] code, input logic [PH_W-1:0] ph);
        logic v;
        v = 1'b0;
        case (code)
            PAT_OFF:  v = 1'b0;
            PAT_ON:   v = 1'b1;
            PAT_SLOW: v = ph[3];
            PAT_FAST: v = ph[1];
            default:  v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/led_status_sched_pattern.sv
// led_pattern_gen: prescaler, blink phase counter and next-value LED decode.
// Optional idle heartbeat on led0 when LED_STATUS_HEARTBEAT_EN is defined.
module led_pattern_gen
    import led_status_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ph_clear,
    input  logic       show,
    input  logic [3:0] pat_q,
    output logic       tick,
    output logic       led0_n,
    output logic       led1_n
);

    logic [PRESCALE_W-1:0] presc_q;
    logic [PH_W-1:0]       ph_q;

    assign tick = &presc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            ph_q    <= '0;
        end else begin
            presc_q <= presc_q + PRESCALE_W'(1);
            // A new grant restarts the blink so every indication begins at the same phase.
            if (ph_clear) begin
                ph_q <= '0;
            end else if (tick) begin
                ph_q <= ph_q + PH_W'(1);
            end
        end
    end

    always_comb begin
        led0_n = 1'b0;
        led1_n = 1'b0;
        if (show) begin
            led0_n = pat_decode(pat_q[1:0], ph_q);
            led1_n = pat_decode(pat_q[3:2], ph_q);
        end else begin
`ifdef LED_STATUS_HEARTBEAT_EN
            led0_n = ph_q[3];
`else
            led0_n = 1'b0;
`endif
        end
    end

endmodule

// File: rtl/led_status_sched.sv
// Fixed-priority LED owner arbiter with minimum hold time; drives the two board LEDs.
// Optional idle heartbeat is selected with LED_STATUS_HEARTBEAT_EN (see led_pattern_gen).
module led_status_sched
    import led_status_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned PRESCALE_W = 20,
    parameter int unsigned HOLD_TICKS = 16
) (
    input  logic              clk_tcxo,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] pat,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              led0,
    output logic              led1
);

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS);

    state_t          state_q;
    logic [7:0]      hold_q;
    logic [3:0]      pat_q;
    logic [NREQ-1:0] winner;
    logic            win_found;
    logic [3:0]      win_pat;
    logic [3:0]      own_pat;
    logic            any_req;
    logic            owner_req;
    logic            ph_clear;
    logic            tick;
    logic            led0_n;
    logic            led1_n;

    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        win_pat   = '0;
        own_pat   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !win_found) begin
                winner[i] = 1'b1;
                win_found = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (winner[i]) win_pat = pat[4*i +: 4];
            if (grant[i])  own_pat = pat[4*i +: 4];
        end
    end

    assign any_req   = |req;
    assign owner_req = |(req & grant);
    // Re-granting the current owner must not restart its blink.
    assign ph_clear  = any_req && ((state_q == IDLE) || ((state_q == REARB) && (winner != grant)));

    led_pattern_gen #(
        .PRESCALE_W (PRESCALE_W)
    ) u_pattern (
        .clk      (clk_tcxo),
        .rst_n    (reset_n),
        .ph_clear (ph_clear),
        .show     (state_q != IDLE),
        .pat_q    (pat_q),
        .tick     (tick),
        .led0_n   (led0_n),
        .led1_n   (led1_n)
    );

    always_ff @(posedge clk_tcxo or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            pat_q   <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            led0    <= 1'b0;
            led1    <= 1'b0;
        end else begin
            led0 <= led0_n;
            led1 <= led1_n;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant   <= winner;
                        busy    <= 1'b1;
                        hold_q  <= HOLD_INIT;
                        pat_q   <= win_pat;
                        state_q <= SHOW;
                    end else begin
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                SHOW: begin
                    // An owner that drops its request keeps its last pattern until hold expires.
                    if (owner_req) pat_q <= own_pat;
                    if (hold_q == '0) begin
                        state_q <= REARB;
                    end else if (tick) begin
                        hold_q <= hold_q - 8'd1;
                    end
                end
                REARB: begin
                    if (any_req) begin
                        grant   <= winner;
                        busy    <= 1'b1;
                        hold_q  <= HOLD_INIT;
                        pat_q   <= win_pat;
                        state_q <= SHOW;
                    end else begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        hold_q  <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    grant   <= '0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_status_sched.sv
// Directed self-checking bench for led_status_sched (PRESCALE_W=4, HOLD_TICKS=2).
// Cycle numbers count rising edges since the last reset release; ticks land on multiples of 16.
module tb_led_status_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] pat;
    logic [3:0]  grant;
    logic        busy;
    logic        led0;
    logic        led1;
    int          cyc;
    int          checks = 0;
    int          errors = 0;

    led_status_sched #(
        .NREQ       (4),
        .PRESCALE_W (4),
        .HOLD_TICKS (2)
    ) dut (
        .clk_tcxo (clk),
        .reset_n  (rst_n),
        .req      (req),
        .pat      (pat),
        .grant    (grant),
        .busy     (busy),
        .led0     (led0),
        .led1     (led1)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic go_to(input int n);
        int g;
        g = 0;
        while (cyc != n && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL go_to: reached cycle %0d, wanted %0d", cyc, n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        pat   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        int toggles;
        int exp_toggles;
        logic prev;
        rst_n = 1'b0;
        req   = '0;
        pat   = '0;
        #12;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (led0 !== 1'b0) begin errors++; $display("FAIL reset_led0 got %b want 0", led0); end
        checks++; if (led1 !== 1'b0) begin errors++; $display("FAIL reset_led1 got %b want 0", led1); end
        @(negedge clk);
        rst_n   = 1'b1;
        bad     = 0;
        toggles = 0;
        prev    = led0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (grant !== 4'b0000 || busy !== 1'b0 || led1 !== 1'b0) bad++;
            if (led0 !== prev) toggles++;
            prev = led0;
        end
`ifdef LED_STATUS_HEARTBEAT_EN
        exp_toggles = 1;
`else
        exp_toggles = 0;
`endif
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_quiet got %0d bad cycles want 0", bad); end
        checks++; if (toggles !== exp_toggles) begin errors++; $display("FAIL idle_led0_toggles got %0d want %0d", toggles, exp_toggles); end
    endtask

    task automatic test_single_owner();
        do_reset();
        go_to(16);
        req = 4'b0100;
        pat = 16'h0700;  // requester 2: led1 on, led0 fast
        go_to(17);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", grant); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        checks++; if (led1 !== 1'b0) begin errors++; $display("FAIL single_led1_early got %b want 0", led1); end
        go_to(18);
        checks++; if (led1 !== 1'b1) begin errors++; $display("FAIL single_led1 got %b want 1", led1); end
        checks++; if (led0 !== 1'b0) begin errors++; $display("FAIL single_led0_start got %b want 0", led0); end
        go_to(40);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant_held got %b want 0100", grant); end
        go_to(48);
        checks++; if (led0 !== 1'b0) begin errors++; $display("FAIL fast_c48 got %b want 0", led0); end
        go_to(49);
        checks++; if (led0 !== 1'b1) begin errors++; $display("FAIL fast_c49 got %b want 1", led0); end
        go_to(50);
        checks++; if (led1 !== 1'b1) begin errors++; $display("FAIL rearb_led1 got %b want 1", led1); end
        go_to(80);
        checks++; if (led0 !== 1'b1) begin errors++; $display("FAIL fast_c80 got %b want 1", led0); end
        go_to(81);
        checks++; if (led0 !== 1'b0) begin errors++; $display("FAIL fast_c81 got %b want 0", led0); end
    endtask

    task automatic test_preempt();
        do_reset();
        go_to(16);
        req = 4'b0100;
        pat = 16'h0303;  // requesters 0 and 2: led0 fast
        go_to(17);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL pre_grant got %b want 0100", grant); end
        go_to(32);
        req = 4'b0101;
        go_to(33);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL pre_nopreempt33 got %b want 0100", grant); end
        go_to(48);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL pre_nopreempt48 got %b want 0100", grant); end
        go_to(49);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL pre_rearb got %b want 0100", grant); end
        checks++; if (led0 !== 1'b1) begin errors++; $display("FAIL pre_led0_old got %b want 1", led0); end
        go_to(50);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL pre_switch got %b want 0001", grant); end
        go_to(51);
        checks++; if (led0 !== 1'b0) begin errors++; $display("FAIL pre_ph_restart got %b want 0", led0); end
    endtask

    task automatic test_same_cycle();
        int bad;
        do_reset();
        go_to(16);
        req = 4'b0011;
        pat = 16'h0004;  // requester 0: led1 on
        bad = 0;
        for (int n = 17; n <= 40; n++) begin
            go_to(n);
            if (grant !== 4'b0001) bad++;
        end
        pat = 16'h0000;
        go_to(41);
        checks++; if (led1 !== 1'b1) begin errors++; $display("FAIL same_led1_old got %b want 1", led1); end
        go_to(42);
        checks++; if (led1 !== 1'b0) begin errors++; $display("FAIL same_pat_reload got %b want 0", led1); end
        for (int n = 43; n <= 80; n++) begin
            go_to(n);
            if (grant !== 4'b0001) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL same_only_req0 got %0d bad cycles want 0", bad); end
        req = 4'b0010;
        go_to(81);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL same_rearb got %b want 0001", grant); end
        go_to(82);
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL same_handover got %b want 0010", grant); end
    endtask

    task automatic test_drop_hold();
        do_reset();
        go_to(16);
        req = 4'b0001;
        pat = 16'h0005;  // requester 0: both LEDs on
        go_to(18);
        checks++; if ({led1, led0} !== 2'b11) begin errors++; $display("FAIL drop_leds_on got %b want 11", {led1, led0}); end
        go_to(20);
        req = 4'b0000;
        pat = 16'h0000;
        go_to(30);
        checks++; if ({led1, led0} !== 2'b11) begin errors++; $display("FAIL drop_frozen30 got %b want 11", {led1, led0}); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy got %b want 1", busy); end
        go_to(49);
        checks++; if ({led1, led0} !== 2'b11) begin errors++; $display("FAIL drop_frozen49 got %b want 11", {led1, led0}); end
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL drop_grant49 got %b want 0001", grant); end
        go_to(50);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL drop_idle_grant got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle_busy got %b want 0", busy); end
        go_to(51);
        checks++; if ({led1, led0} !== 2'b00) begin errors++; $display("FAIL drop_idle_leds got %b want 00", {led1, led0}); end
    endtask

    task automatic test_async_reset();
        do_reset();
        go_to(16);
        req = 4'b0001;
        pat = 16'h0005;
        go_to(25);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL arst_grant got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
        checks++; if ({led1, led0} !== 2'b00) begin errors++; $display("FAIL arst_leds got %b want 00", {led1, led0}); end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL arst_regrant got %b want 0001", grant); end
        checks++; if (led0 !== 1'b0) begin errors++; $display("FAIL arst_led_latency got %b want 0", led0); end
        @(posedge clk);
        #1;
        checks++; if ({led1, led0} !== 2'b11) begin errors++; $display("FAIL arst_leds_on got %b want 11", {led1, led0}); end
    endtask

    initial begin
        test_reset();
        test_single_owner();
        test_preempt();
        test_same_cycle();
        test_drop_hold();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
